// File: rtl/controlador_refresco_display.sv
`default_nettype none
// ============================================================================
// Module      : controlador_refresco_display
// Description : Time-multiplexed refresh scheduler for an N-digit 7-segment
//               display. Lights one active-low anode at a time, inserts a
//               blanking gap between digits to avoid ghosting, and accepts new
//               display words over a valid/ready handshake. A new word is
//               applied only at a frame boundary, so a single frame never
//               mixes old and new digits.
// Ports       : reloj              - system clock (posedge)
//               reinicio_n         - asynchronous active-low reset
//               dato_valido        - producer offers dato_entrada
//               dato_listo         - block can accept a word
//               dato_entrada       - packed nibbles, digit k = [4k+3:4k]
//               anodos             - active-low digit enables (one low max)
//               nibble_activo      - nibble of the lit digit (0 when blanked)
//               digito_sel         - index of the current/next digit
//               tick_actualizacion - pulse on the last lit cycle of a digit
// Revision    : 1.0 - initial release
// ============================================================================
module controlador_refresco_display #(
    parameter int DIV_REFRESCO = 50000,
    parameter int T_BLANCO     = 16,
    parameter int N_DIGITOS    = 4,
    parameter int ANCHO_SEL    = 2
) (
    input  logic                     reloj,
    input  logic                     reinicio_n,
    input  logic                     dato_valido,
    output logic                     dato_listo,
    input  logic [4*N_DIGITOS-1:0]   dato_entrada,
    output logic [N_DIGITOS-1:0]     anodos,
    output logic [3:0]               nibble_activo,
    output logic [ANCHO_SEL-1:0]     digito_sel,
    output logic                     tick_actualizacion
);

    localparam int c_MAX_CNT   = (DIV_REFRESCO > T_BLANCO) ? DIV_REFRESCO : T_BLANCO;
    localparam int c_ANCHO_CNT = (c_MAX_CNT > 1) ? $clog2(c_MAX_CNT) : 1;
    localparam int c_ANCHO_DATO = 4 * N_DIGITOS;

    localparam logic [c_ANCHO_CNT-1:0] c_FIN_MOSTRAR = c_ANCHO_CNT'(DIV_REFRESCO - 1);
    localparam logic [c_ANCHO_CNT-1:0] c_FIN_BLANCO  = c_ANCHO_CNT'(T_BLANCO - 1);
    localparam logic [c_ANCHO_CNT-1:0] c_UNO_CNT     = c_ANCHO_CNT'(1);
    localparam logic [ANCHO_SEL-1:0]   c_ULTIMO_SEL  = ANCHO_SEL'(N_DIGITOS - 1);
    localparam logic [ANCHO_SEL-1:0]   c_UNO_SEL     = ANCHO_SEL'(1);

    typedef enum logic [0:0] {
        ST_BLANCO  = 1'b0,
        ST_MOSTRAR = 1'b1
    } estado_t;

    estado_t                    estado_q, estado_d;
    logic [c_ANCHO_CNT-1:0]     cnt_q, cnt_d;
    logic [ANCHO_SEL-1:0]       sel_q, sel_d;
    logic [c_ANCHO_DATO-1:0]    display_q, display_d;
    logic [c_ANCHO_DATO-1:0]    pendiente_q, pendiente_d;
    logic                       pendiente_lleno_q, pendiente_lleno_d;
    logic [N_DIGITOS-1:0]       anodos_q, anodos_d;
    logic [3:0]                 nibble_q, nibble_d;
    logic                       tick_q, tick_d;
    logic                       listo_q, listo_d;

    logic                       w_fin_digito;
    logic                       w_frontera;
    logic                       w_handshake;

    always_comb begin
        w_fin_digito = (estado_q == ST_MOSTRAR) && (cnt_q == c_FIN_MOSTRAR);
        // Frame boundary: leaving the last digit, i.e. the select wraps to 0.
        w_frontera   = w_fin_digito && (sel_q == c_ULTIMO_SEL);
        w_handshake  = dato_valido && listo_q;

        // ---------------- sequencing ----------------
        estado_d = estado_q;
        cnt_d    = cnt_q + c_UNO_CNT;
        sel_d    = sel_q;
        case (estado_q)
            ST_BLANCO: begin
                if (cnt_q == c_FIN_BLANCO) begin
                    cnt_d    = '0;
                    estado_d = ST_MOSTRAR;
                end
            end
            ST_MOSTRAR: begin
                if (w_fin_digito) begin
                    cnt_d    = '0;
                    estado_d = ST_BLANCO;
                    sel_d    = (sel_q == c_ULTIMO_SEL) ? '0 : (sel_q + c_UNO_SEL);
                end
            end
            default: begin
                cnt_d    = '0;
                estado_d = ST_BLANCO;
            end
        endcase

        // ---------------- data path ----------------
        // The pending buffer only drains at a frame boundary. When it is
        // full, listo is low, so a boundary never sees a pending word and a
        // fresh handshake at the same time.
        display_d         = display_q;
        pendiente_d       = pendiente_q;
        pendiente_lleno_d = pendiente_lleno_q;
        if (w_frontera) begin
            if (pendiente_lleno_q) begin
                display_d         = pendiente_q;
                pendiente_lleno_d = 1'b0;
            end else if (w_handshake) begin
                display_d = dato_entrada;
            end
        end else if (w_handshake) begin
            pendiente_d       = dato_entrada;
            pendiente_lleno_d = 1'b1;
        end

        // ---------------- registered outputs ----------------
        // Outputs are computed from next-state values so they line up with
        // the state register rather than lagging it by a cycle.
        anodos_d = '1;
        nibble_d = '0;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if ((estado_d == ST_MOSTRAR) && (sel_d == ANCHO_SEL'(k))) begin
                anodos_d[k] = 1'b0;
                nibble_d    = display_d[4*k +: 4];
            end
        end
        tick_d  = (estado_d == ST_MOSTRAR) && (cnt_d == c_FIN_MOSTRAR);
        listo_d = ~pendiente_lleno_d;
    end

    // reinicio_n is expected to be released synchronously by the upstream
    // reset synchronizer; assertion takes effect immediately.
    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            estado_q          <= ST_BLANCO;
            cnt_q             <= '0;
            sel_q             <= '0;
            display_q         <= '0;
            pendiente_q       <= '0;
            pendiente_lleno_q <= 1'b0;
            anodos_q          <= '1;
            nibble_q          <= '0;
            tick_q            <= 1'b0;
            listo_q           <= 1'b1;
        end else begin
            estado_q          <= estado_d;
            cnt_q             <= cnt_d;
            sel_q             <= sel_d;
            display_q         <= display_d;
            pendiente_q       <= pendiente_d;
            pendiente_lleno_q <= pendiente_lleno_d;
            anodos_q          <= anodos_d;
            nibble_q          <= nibble_d;
            tick_q            <= tick_d;
            listo_q           <= listo_d;
        end
    end

    assign dato_listo         = listo_q;
    assign anodos             = anodos_q;
    assign nibble_activo      = nibble_q;
    assign digito_sel         = sel_q;
    assign tick_actualizacion = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_controlador_refresco_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_refresco_display
// Description : Bench for controlador_refresco_display. Two instances share a
//               clock and reset: a 4-digit one and a 1-digit one (both with an
//               8-cycle lit time and a 2-cycle blank). Expected outputs come
//               from a cycle-count model: the position inside the digit
//               period and the digit slot are derived arithmetically from the
//               number of clock edges since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_refresco_display;

    localparam int DIV = 8;
    localparam int TB  = 2;
    localparam int P   = DIV + TB;

    logic reloj = 1'b0;
    logic reinicio_n = 1'b0;
    always #5 reloj = ~reloj;

    // stimulus per instance
    bit mv[2];
    int md[2];

    logic        v0, l0, t0;
    logic [15:0] d0;
    logic [3:0]  a0, n0;
    logic [1:0]  s0;
    logic        v1, l1, t1;
    logic [3:0]  d1;
    logic [0:0]  a1, s1;
    logic [3:0]  n1;

    assign v0 = mv[0];
    assign d0 = md[0][15:0];
    assign v1 = mv[1];
    assign d1 = md[1][3:0];

    controlador_refresco_display #(
        .DIV_REFRESCO(DIV), .T_BLANCO(TB), .N_DIGITOS(4), .ANCHO_SEL(2)
    ) u_dut4 (
        .reloj(reloj), .reinicio_n(reinicio_n),
        .dato_valido(v0), .dato_listo(l0), .dato_entrada(d0),
        .anodos(a0), .nibble_activo(n0), .digito_sel(s0), .tick_actualizacion(t0)
    );

    controlador_refresco_display #(
        .DIV_REFRESCO(DIV), .T_BLANCO(TB), .N_DIGITOS(1), .ANCHO_SEL(1)
    ) u_dut1 (
        .reloj(reloj), .reinicio_n(reinicio_n),
        .dato_valido(v1), .dato_listo(l1), .dato_entrada(d1),
        .anodos(a1), .nibble_activo(n1), .digito_sel(s1), .tick_actualizacion(t1)
    );

    // reference model state
    int m_n[2];
    int m_c[2];      // clock edges since reset release
    int m_disp[2];
    int m_pend[2];
    bit m_pf[2];
    bit m_acc[2];    // last offer was accepted

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_valor(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_c[k] = 0; m_disp[k] = 0; m_pend[k] = 0; m_pf[k] = 0; m_acc[k] = 0;
            mv[k] = 0;
        end
    endtask

    function automatic int fase(input int k);
        return m_c[k] % P;
    endfunction

    function automatic int digito(input int k);
        return (m_c[k] / P) % m_n[k];
    endfunction

    task automatic check_all();
        logic [31:0] oa[2], on[2], os[2], ot[2], ol[2];
        int todos, dg, ph;
        bit lit;
        oa[0] = 32'(a0); on[0] = 32'(n0); os[0] = 32'(s0); ot[0] = 32'(t0); ol[0] = 32'(l0);
        oa[1] = 32'(a1); on[1] = 32'(n1); os[1] = 32'(s1); ot[1] = 32'(t1); ol[1] = 32'(l1);
        for (int k = 0; k < 2; k++) begin
            todos = (1 << m_n[k]) - 1;
            ph    = fase(k);
            dg    = digito(k);
            lit   = (ph >= TB);
            check_valor($sformatf("n%0d anodos", m_n[k]), oa[k],
                        lit ? (todos & ~(1 << dg)) : todos);
            check_valor($sformatf("n%0d nibble", m_n[k]), on[k],
                        lit ? ((m_disp[k] >> (4*dg)) & 15) : 0);
            check_valor($sformatf("n%0d sel", m_n[k]), os[k], dg);
            check_valor($sformatf("n%0d tick", m_n[k]), ot[k], (ph == P-1) ? 1 : 0);
            check_valor($sformatf("n%0d listo", m_n[k]), ol[k], m_pf[k] ? 0 : 1);
        end
    endtask

    // Producer: holds an offered word until accepted. Mode 0 = idle,
    // 1 = random offers, 2 = offer only on the edge that ends a frame.
    task automatic drive(input int k, input int mode);
        int ph   = fase(k);
        int dg   = digito(k);
        int mask = (1 << (4*m_n[k])) - 1;
        if (!(mv[k] && !m_acc[k])) begin
            mv[k] = 0;
            md[k] = int'($urandom) & mask;
            if (mode == 1 && $urandom_range(0, 3) == 0)
                mv[k] = 1;
            if (mode == 2 && ph == P-1 && dg == m_n[k]-1 && !m_pf[k])
                mv[k] = 1;
        end
    endtask

    task automatic model_edge(input int k);
        bit hs  = mv[k] && !m_pf[k];
        bit bnd = (fase(k) == P-1) && (digito(k) == m_n[k]-1);
        if (bnd) begin
            if (m_pf[k]) begin
                m_disp[k] = m_pend[k];
                m_pf[k]   = 0;
            end else if (hs) begin
                m_disp[k] = md[k];
            end
        end else if (hs) begin
            m_pend[k] = md[k];
            m_pf[k]   = 1;
        end
        m_acc[k] = hs;
        m_c[k]++;
    endtask

    task automatic run(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            @(negedge reloj);
            check_all();
            drive(0, mode);
            drive(1, mode);
            @(posedge reloj);
            if (reinicio_n) begin
                model_edge(0);
                model_edge(1);
            end
        end
    endtask

    initial begin
        bit hallado;
        m_n[0] = 4;
        m_n[1] = 1;
        md[0] = 0;
        md[1] = 0;
        model_reset();

        // reset held: reset values
        run(3, 0);
        @(posedge reloj);
        #2 reinicio_n = 1'b1;

        // no data: blank/lit pattern, ticks, nibble stays 0
        run(45, 0);
        // random producer, including stalls while pending is full
        run(400, 1);
        // handshakes exactly on frame boundaries with pending empty
        run(200, 2);

        // reach digit 2 lit on the 4-digit instance with a word pending
        hallado = 0;
        for (int i = 0; i < 2000 && !hallado; i++) begin
            run(1, 1);
            if (m_pf[0] && fase(0) >= TB && digito(0) == 2)
                hallado = 1;
        end
        check_valor("espera_reset", 32'(hallado), 1);

        // asynchronous reset mid-frame
        #2 reinicio_n = 1'b0;
        model_reset();
        #1 check_all();
        run(3, 0);
        @(posedge reloj);
        #2 reinicio_n = 1'b1;

        // pending word must be gone: display starts from 0 again
        run(30, 0);
        run(300, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
